// File: rtl/mux_channel_scanner_pkg.sv
// Shared definitions for the 6-to-1 mux channel scanner.
//   state_t   : scanner FSM states
//   NUM_CH    : number of mux channels
//   SEL_W     : mux select width
//   PARK_SEL_DEF : default idle select (6 or 7 so the mux outputs 0)
//   next_en() : next enabled channel strictly above a given index
//   first_en(): lowest enabled channel
package mux_channel_scanner_pkg;

  localparam int unsigned NUM_CH = 6;
  localparam int unsigned SEL_W  = 3;
  localparam logic [SEL_W-1:0] PARK_SEL_DEF = 3'b110;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    HOLD
  } state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } chan_pick_t;

  function automatic chan_pick_t next_en(input logic [NUM_CH-1:0] mask,
                                         input logic [SEL_W-1:0]  cur);
    chan_pick_t r;
    r = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!r.found && mask[i] && (i > 32'(cur))) begin
        r.found = 1'b1;
        r.idx   = SEL_W'(i);
      end
    end
    return r;
  endfunction

  function automatic chan_pick_t first_en(input logic [NUM_CH-1:0] mask);
    chan_pick_t r;
    r = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!r.found && mask[i]) begin
        r.found = 1'b1;
        r.idx   = SEL_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_channel_scanner_if.sv
// Signal bundle between the scanner, the mux it drives and the snapshot sink.
//   start/cont/chan_en : scan control
//   sel/mux_out        : mux select out, mux data back
//   snap/snap_valid/snap_ready : snapshot handshake
//   busy               : scan or hold in progress
// modport master: the scanner side; modport slave: the environment side.
interface mux_channel_scanner_if;
  import mux_channel_scanner_pkg::*;

  logic              start;
  logic              cont;
  logic [NUM_CH-1:0] chan_en;
  logic [SEL_W-1:0]  sel;
  logic              mux_out;
  logic [NUM_CH-1:0] snap;
  logic              snap_valid;
  logic              snap_ready;
  logic              busy;

  modport master (
    input  start, cont, chan_en, mux_out, snap_ready,
    output sel, snap, snap_valid, busy
  );

  modport slave (
    output start, cont, chan_en, mux_out, snap_ready,
    input  sel, snap, snap_valid, busy
  );

endinterface

// File: rtl/mux_next_chan.sv
// Priority picker: next enabled channel strictly above cur.
//   mask  : channel enable mask
//   cur   : current channel index
//   found : a higher enabled channel exists
//   nxt   : its index (0 when not found)
module mux_next_chan
  import mux_channel_scanner_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  cur,
  output logic              found,
  output logic [SEL_W-1:0]  nxt
);

  chan_pick_t pick;

  always_comb begin
    pick  = next_en(mask, cur);
    found = pick.found;
    nxt   = pick.idx;
  end

endmodule

// File: rtl/mux_channel_scanner.sv
// Sequencer ahead of a 6-to-1 bit mux: steps sel through the enabled
// channels, holds each for DWELL cycles, samples mux_out at the end of the
// last dwell cycle and presents the packed 6-bit snapshot on a valid/ready
// handshake. Single-shot or continuous.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mux_channel_scanner_if.master (control, mux, snapshot)
// Parameters: DWELL (1..15) cycles per channel, PARK_SEL (6 or 7) idle select.
module mux_channel_scanner
  import mux_channel_scanner_pkg::*;
#(
  parameter int unsigned      DWELL    = 2,
  parameter logic [SEL_W-1:0] PARK_SEL = PARK_SEL_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  mux_channel_scanner_if.master bus
);

  localparam logic [3:0] DWELL_RELOAD = 4'(DWELL - 1);

  state_t            state;
  logic [NUM_CH-1:0] en_q;
  logic [NUM_CH-1:0] snap_q;
  logic [SEL_W-1:0]  sel_q;
  logic [3:0]        cnt;
  logic              valid_q;
  logic              busy_q;

  logic              nxt_found;
  logic [SEL_W-1:0]  nxt_idx;
  chan_pick_t        launch_pick;
  logic              handshake;
  logic              do_launch;

  mux_next_chan u_next (
    .mask  (en_q),
    .cur   (sel_q),
    .found (nxt_found),
    .nxt   (nxt_idx)
  );

  // Start from IDLE and a continuous re-arm at handshake share one launch
  // path so both have identical timing.
  always_comb begin
    launch_pick = first_en(bus.chan_en);
    handshake   = (state == HOLD) && valid_q && bus.snap_ready;
    do_launch   = ((state == IDLE) && bus.start) || (handshake && bus.cont);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      en_q    <= '0;
      snap_q  <= '0;
      sel_q   <= PARK_SEL;
      cnt     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else if (do_launch) begin
      en_q   <= bus.chan_en;
      snap_q <= '0;
      cnt    <= DWELL_RELOAD;
      busy_q <= 1'b1;
      if (launch_pick.found) begin
        state   <= SCAN;
        sel_q   <= launch_pick.idx;
        valid_q <= 1'b0;
      end else begin
        // empty mask: an all-zero snapshot is ready immediately
        state   <= HOLD;
        sel_q   <= PARK_SEL;
        valid_q <= 1'b1;
      end
    end else begin
      case (state)
        IDLE: begin
          sel_q <= PARK_SEL;
        end
        SCAN: begin
          if (cnt == '0) begin
            snap_q[sel_q] <= bus.mux_out;
            if (nxt_found) begin
              sel_q <= nxt_idx;
              cnt   <= DWELL_RELOAD;
            end else begin
              state   <= HOLD;
              sel_q   <= PARK_SEL;
              valid_q <= 1'b1;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          if (handshake) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          sel_q   <= PARK_SEL;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sel        = sel_q;
  assign bus.snap       = snap_q;
  assign bus.snap_valid = valid_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_mux_channel_scanner.sv
module tb_mux_channel_scanner;
  import mux_channel_scanner_pkg::*;

  logic clk;
  logic rst;
  logic [5:0] in_vec;
  logic [7:0] in_ext;

  int tests;
  int fails;
  logic [5:0] exp_q[$];

  mux_channel_scanner_if bus ();

  mux_channel_scanner #(.DWELL(2), .PARK_SEL(3'b110)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mux model: select 6/7 yields 0
  always_comb begin
    in_ext      = {2'b00, in_vec};
    bus.mux_out = in_ext[bus.sel];
  end

  // scoreboard monitor: compare each accepted snapshot with the queue head
  always @(negedge clk) begin
    if (!rst && bus.snap_valid && bus.snap_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL snap_unexpected: got %b, required no snapshot", bus.snap);
      end else begin
        logic [5:0] e;
        e = exp_q.pop_front();
        if (bus.snap !== e) begin
          fails++;
          $display("FAIL snap_scoreboard: got %b, required %b", bus.snap, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    in_vec = '0;
    bus.start = 1'b0;
    bus.cont = 1'b0;
    bus.chan_en = '0;
    bus.snap_ready = 1'b0;
    step(2);
    chk("rst_sel", 8'(bus.sel), 8'd6);
    chk("rst_snap", 8'(bus.snap), 8'd0);
    chk("rst_valid", 8'(bus.snap_valid), 8'd0);
    chk("rst_busy", 8'(bus.busy), 8'd0);
    rst = 1'b0;
    step(1);

    // full mask, single shot
    in_vec = 6'b101101;
    bus.chan_en = 6'b111111;
    bus.snap_ready = 1'b1;
    exp_q.push_back(6'b101101);
    bus.start = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step(1);
      bus.start = 1'b0;
      if (k <= 12) begin
        chk("full_sel", 8'(bus.sel), 8'((k - 1) / 2));
        chk("full_busy", 8'(bus.busy), 8'd1);
      end else if (k == 13) begin
        chk("full_valid", 8'(bus.snap_valid), 8'd1);
        chk("full_snap", 8'(bus.snap), 8'b101101);
        chk("full_park", 8'(bus.sel), 8'd6);
      end else begin
        chk("full_vdrop", 8'(bus.snap_valid), 8'd0);
        chk("full_idle", 8'(bus.busy), 8'd0);
        chk("full_park2", 8'(bus.sel), 8'd6);
      end
    end

    // sparse mask
    in_vec = 6'b111111;
    bus.chan_en = 6'b100100;
    exp_q.push_back(6'b100100);
    bus.start = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      bus.start = 1'b0;
      if (k <= 2) chk("sparse_sel2", 8'(bus.sel), 8'd2);
      else if (k <= 4) chk("sparse_sel5", 8'(bus.sel), 8'd5);
      else if (k == 5) begin
        chk("sparse_valid", 8'(bus.snap_valid), 8'd1);
        chk("sparse_snap", 8'(bus.snap), 8'b100100);
      end else chk("sparse_vdrop", 8'(bus.snap_valid), 8'd0);
    end

    // empty mask
    bus.chan_en = 6'b000000;
    exp_q.push_back(6'b000000);
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    chk("empty_valid", 8'(bus.snap_valid), 8'd1);
    chk("empty_snap", 8'(bus.snap), 8'd0);
    chk("empty_sel", 8'(bus.sel), 8'd6);
    step(1);
    chk("empty_vdrop", 8'(bus.snap_valid), 8'd0);
    chk("empty_sel2", 8'(bus.sel), 8'd6);

    // backpressure
    bus.snap_ready = 1'b0;
    bus.chan_en = 6'b111111;
    in_vec = 6'b101010;
    exp_q.push_back(6'b101010);
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    step(12);
    chk("bp_valid_rise", 8'(bus.snap_valid), 8'd1);
    for (int j = 0; j < 10; j++) begin
      in_vec = 6'(j * 7);
      bus.start = (j % 2) == 1;
      chk("bp_snap_hold", 8'(bus.snap), 8'b101010);
      chk("bp_valid_hold", 8'(bus.snap_valid), 8'd1);
      chk("bp_sel_park", 8'(bus.sel), 8'd6);
      step(1);
    end
    bus.start = 1'b0;
    bus.snap_ready = 1'b1;
    chk("bp_valid_pre", 8'(bus.snap_valid), 8'd1);
    step(1);
    chk("bp_vdrop", 8'(bus.snap_valid), 8'd0);
    chk("bp_idle", 8'(bus.busy), 8'd0);
    step(1);
    chk("bp_no_rescan", 8'(bus.busy), 8'd0);

    // continuous mode
    bus.cont = 1'b1;
    bus.snap_ready = 1'b0;
    bus.chan_en = 6'b111111;
    in_vec = 6'b111000;
    exp_q.push_back(6'b111000);
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    step(4);
    bus.chan_en = 6'b000011;
    chk("cont_mask_ignored", 8'(bus.sel), 8'd2);
    step(8);
    chk("cont_valid1", 8'(bus.snap_valid), 8'd1);
    chk("cont_snap1", 8'(bus.snap), 8'b111000);
    in_vec = 6'b000111;
    exp_q.push_back(6'b000011);
    step(1);
    bus.snap_ready = 1'b1;
    step(1);
    bus.snap_ready = 1'b0;
    chk("cont_sel_live", 8'(bus.sel), 8'd0);
    chk("cont_valid_drop", 8'(bus.snap_valid), 8'd0);
    chk("cont_snap_clr", 8'(bus.snap), 8'd0);
    chk("cont_busy", 8'(bus.busy), 8'd1);
    step(2);
    chk("cont_sel1", 8'(bus.sel), 8'd1);
    step(2);
    chk("cont_valid2", 8'(bus.snap_valid), 8'd1);
    chk("cont_snap2", 8'(bus.snap), 8'b000011);
    bus.cont = 1'b0;
    bus.snap_ready = 1'b1;
    step(1);
    chk("cont_end_valid", 8'(bus.snap_valid), 8'd0);
    chk("cont_end_busy", 8'(bus.busy), 8'd0);

    // reset mid-scan
    bus.chan_en = 6'b111111;
    in_vec = 6'b111111;
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    step(6);
    chk("rstm_sel3", 8'(bus.sel), 8'd3);
    rst = 1'b1;
    step(1);
    chk("rstm_sel", 8'(bus.sel), 8'd6);
    chk("rstm_snap", 8'(bus.snap), 8'd0);
    chk("rstm_valid", 8'(bus.snap_valid), 8'd0);
    chk("rstm_busy", 8'(bus.busy), 8'd0);
    rst = 1'b0;
    step(1);
    in_vec = 6'b110011;
    exp_q.push_back(6'b110011);
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    chk("rstm_rescan_sel", 8'(bus.sel), 8'd0);
    step(12);
    chk("rstm_valid2", 8'(bus.snap_valid), 8'd1);
    chk("rstm_snap2", 8'(bus.snap), 8'b110011);
    step(1);
    chk("rstm_vdrop", 8'(bus.snap_valid), 8'd0);

    step(2);
    chk("queue_drained", 8'(exp_q.size()), 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
